// File: rtl/store_buffer_pkg.sv
// Shared types for the store buffer: entry layout, byte-enable constants and drain FSM encoding.
// Entries hold a zero-extended word address so one struct serves any ADDR_W up to MAX_ADDR_W.
package store_buffer_pkg;

    localparam int MAX_ADDR_W = 32;
    localparam int WADDR_W    = MAX_ADDR_W - 2;

    localparam logic [3:0] BE_WORD = 4'b1111;
    localparam logic [3:0] BE_NONE = 4'b0000;

    typedef struct packed {
        logic [WADDR_W-1:0] waddr;
        logic [31:0]        data;
        logic [3:0]         be;
    } sb_entry_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } drain_state_t;

    // Overwrite only the byte lanes selected by be.
    function automatic logic [31:0] merge_lanes(input logic [31:0] old_data,
                                                input logic [31:0] new_data,
                                                input logic [3:0]  be);
        logic [31:0] res;
        res = old_data;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) res[8*i +: 8] = new_data[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/store_buffer_sb_forward.sv
// Combinational load forwarding: per byte lane, picks the youngest valid entry matching the load word.
module sb_forward
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  sb_entry_t          entries [DEPTH],
    input  logic [DEPTH-1:0]   valid,
    input  logic [PTR_W-1:0]   head,
    input  logic [WADDR_W-1:0] ld_waddr,
    input  logic [3:0]         ld_be,
    output logic [31:0]        ld_data,
    output logic               ld_hit,
    output logic               ld_stall
);

    logic [3:0] found;

    // Walk oldest to youngest so a younger match overrides an older one lane by lane.
    always_comb begin
        logic [PTR_W-1:0] idx;
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        ld_data = '0;
        found   = BE_NONE;
        idx     = head;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head + PTR_W'(k);
            if (valid[idx] && entries[idx].waddr == ld_waddr) begin
                for (int i = 0; i < 4; i++) begin
                    if (ld_be[i] && entries[idx].be[i]) begin
                        found[i]          = 1'b1;
                        ld_data[8*i +: 8] = entries[idx].data[8*i +: 8];
                    end
                end
            end
        end
    end

    assign ld_hit   = (ld_be != BE_NONE) && (found == ld_be);
    assign ld_stall = (found != BE_NONE) && (found != ld_be);

endmodule

// File: rtl/store_buffer.sv
// Store buffer between MEM stage and data memory: FIFO of lane-aligned stores drained by req/ack.
// Define STORE_MERGE_EN to merge a same-word push into the youngest entry instead of allocating.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              st_valid,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [31:0]       st_wdata,
    input  logic [3:0]        st_be,
    output logic              st_ready,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [3:0]        ld_be,
    output logic [31:0]       ld_data,
    output logic              ld_hit,
    output logic              ld_stall,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    input  logic              mem_ack
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    sb_entry_t          entries [DEPTH];
    logic [DEPTH-1:0]   valid;
    logic [PTR_W-1:0]   head, tail, youngest;
    logic [CNT_W-1:0]   count, count_next;
    drain_state_t       state, state_next;
    logic [WADDR_W-1:0] st_waddr, ld_waddr;
    logic               push_fire, merge, alloc, pop;
    logic               unused_addr_bits;

    assign st_waddr         = WADDR_W'(st_addr[ADDR_W-1:2]);
    assign ld_waddr         = WADDR_W'(ld_addr[ADDR_W-1:2]);
    assign unused_addr_bits = ^{st_addr[1:0], ld_addr[1:0]};

    assign st_ready  = (count < CNT_W'(DEPTH));
    assign push_fire = st_valid && st_ready && (st_be != BE_NONE);
    assign youngest  = tail - PTR_W'(1);
    assign pop       = (state == ST_REQ) && mem_ack;

`ifdef STORE_MERGE_EN
    // The head is frozen while it is being offered to memory, so it never absorbs a merge then.
    assign merge = push_fire && (count != '0)
                && (entries[youngest].waddr == st_waddr)
                && !((state == ST_REQ) && (count == CNT_W'(1)));
`else
    assign merge = 1'b0;
`endif

    assign alloc      = push_fire && !merge;
    assign count_next = count + CNT_W'(alloc) - CNT_W'(pop);

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (count != '0) state_next = ST_REQ;
            ST_REQ:  if (pop && count_next == '0) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            head  <= '0;
            tail  <= '0;
            count <= '0;
            valid <= '0;
        end else begin
            // NOTE: all state updates use non-blocking assignment so every read sees pre-edge values.
            state <= state_next;
            count <= count_next;
            if (pop) begin
                valid[head] <= 1'b0;
                head        <= head + PTR_W'(1);
            end
            if (alloc) begin
                valid[tail] <= 1'b1;
                tail        <= tail + PTR_W'(1);
            end
        end
    end

    // NOTE: entry payload is not reset; the valid vector and the FSM gate every use of it.
    always_ff @(posedge clk) begin
        if (alloc) begin
            entries[tail] <= '{waddr: st_waddr, data: st_wdata, be: st_be};
        end else if (merge) begin
            entries[youngest].data <= merge_lanes(entries[youngest].data, st_wdata, st_be);
            entries[youngest].be   <= entries[youngest].be | st_be;
        end
    end

    assign mem_req   = (state == ST_REQ);
    assign mem_addr  = mem_req ? {entries[head].waddr[ADDR_W-3:0], 2'b00} : '0;
    assign mem_wdata = mem_req ? entries[head].data : '0;
    assign mem_be    = mem_req ? entries[head].be   : BE_NONE;

    sb_forward #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_forward (
        .entries  (entries),
        .valid    (valid),
        .head     (head),
        .ld_waddr (ld_waddr),
        .ld_be    (ld_be),
        .ld_data  (ld_data),
        .ld_hit   (ld_hit),
        .ld_stall (ld_stall)
    );

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: forwarding vector table plus hand-written drain, fill, merge and reset sequences.
module tb_store_buffer;
    import store_buffer_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        st_valid;
    logic [31:0] st_addr;
    logic [31:0] st_wdata;
    logic [3:0]  st_be;
    logic        st_ready;
    logic [31:0] ld_addr;
    logic [3:0]  ld_be;
    logic [31:0] ld_data;
    logic        ld_hit;
    logic        ld_stall;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;

    int n_run  = 0;
    int n_fail = 0;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
        logic        hit;
        logic        stall;
    } fwd_vec_t;

    fwd_vec_t vecs [10];

    store_buffer #(.DEPTH(4), .ADDR_W(32)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .st_valid  (st_valid),
        .st_addr   (st_addr),
        .st_wdata  (st_wdata),
        .st_be     (st_be),
        .st_ready  (st_ready),
        .ld_addr   (ld_addr),
        .ld_be     (ld_be),
        .ld_data   (ld_data),
        .ld_hit    (ld_hit),
        .ld_stall  (ld_stall),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_ack   (mem_ack)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n  = 1'b0;
        st_valid = 1'b0;
        st_addr  = '0;
        st_wdata = '0;
        st_be    = BE_NONE;
        ld_addr  = '0;
        ld_be    = BE_NONE;
        mem_ack  = 1'b0;
        #12;
        @(negedge clk);
        reset_n = 1'b1;
        tick();
    endtask

    task automatic push(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
        st_valid = 1'b1;
        st_addr  = addr;
        st_wdata = data;
        st_be    = be;
        tick();
        st_valid = 1'b0;
        st_be    = BE_NONE;
    endtask

    task automatic drain_one(input string name, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] be);
        int waited = 0;
        while (!mem_req && waited < 10) begin
            tick();
            waited++;
        end
        check({name, " req"},   mem_req,   1'b1);
        check({name, " addr"},  mem_addr,  a);
        check({name, " wdata"}, mem_wdata, d);
        check({name, " be"},    mem_be,    be);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
    endtask

    task automatic expect_idle(input string name);
        tick();
        tick();
        check({name, " no req"}, mem_req, 1'b0);
        check({name, " ready"},  st_ready, 1'b1);
    endtask

    task automatic load_check(input string name, input logic [31:0] a, input logic [3:0] be,
                              input logic [31:0] d, input logic hit, input logic stall);
        ld_addr = a;
        ld_be   = be;
        #1;
        check({name, " data"},  ld_data,  d);
        check({name, " hit"},   ld_hit,   hit);
        check({name, " stall"}, ld_stall, stall);
    endtask

    initial begin
        vecs[0] = '{32'h200, 4'b0011, 32'h0000_1234, 1'b1, 1'b0};
        vecs[1] = '{32'h200, 4'b1111, 32'h0000_1234, 1'b0, 1'b1};
        vecs[2] = '{32'h204, 4'b1111, 32'h0000_0000, 1'b0, 1'b0};
        vecs[3] = '{32'h300, 4'b0001, 32'h0000_0022, 1'b1, 1'b0};
        vecs[4] = '{32'h300, 4'b1001, 32'hCC00_0022, 1'b1, 1'b0};
        vecs[5] = '{32'h300, 4'b0110, 32'h0000_0000, 1'b0, 1'b0};
        vecs[6] = '{32'h300, 4'b0011, 32'h0000_0022, 1'b0, 1'b1};
        vecs[7] = '{32'h200, 4'b0000, 32'h0000_0000, 1'b0, 1'b0};
        vecs[8] = '{32'h201, 4'b0001, 32'h0000_0034, 1'b1, 1'b0};
        vecs[9] = '{32'h100, 4'b1111, 32'h0000_0000, 1'b0, 1'b0};

        // Reset values, sampled while reset is held.
        reset_n = 1'b0;
        st_valid = 1'b0; st_addr = '0; st_wdata = '0; st_be = BE_NONE;
        ld_addr = '0; ld_be = BE_WORD; mem_ack = 1'b0;
        #3;
        check("rst mem_req",   mem_req,   1'b0);
        check("rst mem_addr",  mem_addr,  32'h0);
        check("rst mem_wdata", mem_wdata, 32'h0);
        check("rst mem_be",    mem_be,    4'h0);
        check("rst st_ready",  st_ready,  1'b1);
        check("rst ld_hit",    ld_hit,    1'b0);
        check("rst ld_stall",  ld_stall,  1'b0);
        check("rst ld_data",   ld_data,   32'h0);
        do_reset();

        // Single store: mem_req one cycle after the push, drops after the ack.
        push(32'h100, 32'hAABB_CCDD, BE_WORD);
        check("single req early", mem_req, 1'b0);
        tick();
        check("single req",   mem_req,   1'b1);
        check("single addr",  mem_addr,  32'h100);
        check("single wdata", mem_wdata, 32'hAABB_CCDD);
        check("single be",    mem_be,    BE_WORD);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("single req after ack", mem_req, 1'b0);
        check("single ready after ack", st_ready, 1'b1);

        // Fill to full, then a pop with a pending store: no bypass into the freed slot.
        push(32'h10, 32'h1000_0000, 4'b1111);
        push(32'h14, 32'h1000_0001, 4'b0011);
        push(32'h18, 32'h1000_0002, 4'b1100);
        push(32'h1C, 32'h1000_0003, 4'b0001);
        check("fill ready full", st_ready, 1'b0);
        check("fill head addr",  mem_addr, 32'h10);
        check("fill head data",  mem_wdata, 32'h1000_0000);
        st_valid = 1'b1; st_addr = 32'h20; st_wdata = 32'hDEAD_BEEF; st_be = BE_WORD;
        mem_ack  = 1'b1;
        #1;
        check("fill ready full+pop", st_ready, 1'b0);
        tick();
        st_valid = 1'b0; st_be = BE_NONE; mem_ack = 1'b0;
        check("fill ready after pop", st_ready, 1'b1);
        drain_one("fill d1", 32'h14, 32'h1000_0001, 4'b0011);
        drain_one("fill d2", 32'h18, 32'h1000_0002, 4'b1100);
        drain_one("fill d3", 32'h1C, 32'h1000_0003, 4'b0001);
        expect_idle("fill end");

        // Forwarding table over a held buffer (no acks).
        do_reset();
        push(32'h200, 32'h0000_1234, 4'b0011);
        push(32'h300, 32'h0000_0011, 4'b0001);
        push(32'h300, 32'h0000_0022, 4'b0001);
        push(32'h300, 32'hCC00_0000, 4'b1000);
`ifdef STORE_MERGE_EN
        check("fwd setup ready", st_ready, 1'b1);
`else
        check("fwd setup ready", st_ready, 1'b0);
`endif
        for (int i = 0; i < 10; i++) begin
            load_check($sformatf("fwd vec%0d", i), vecs[i].addr, vecs[i].be,
                       vecs[i].data, vecs[i].hit, vecs[i].stall);
        end
        // A store pushed this cycle is not yet visible to forwarding.
        st_valid = 1'b0;
        do_reset();
        st_valid = 1'b1; st_addr = 32'h900; st_wdata = 32'h0000_0077; st_be = 4'b0001;
        load_check("fwd same-cycle push", 32'h900, 4'b0001, 32'h0, 1'b0, 1'b0);
        tick();
        st_valid = 1'b0; st_be = BE_NONE;
        load_check("fwd after push", 32'h900, 4'b0001, 32'h77, 1'b1, 1'b0);

        // Merge (or, without merging, two entries) behind two older pending stores.
        do_reset();
        push(32'h500, 32'h5555_5555, BE_WORD);
        push(32'h504, 32'h6666_6666, BE_WORD);
        push(32'h400, 32'h0000_00AA, 4'b0001);
        push(32'h400, 32'h00BB_0000, 4'b0100);
        load_check("merge fwd", 32'h400, 4'b0101, 32'h00BB_00AA, 1'b1, 1'b0);
        drain_one("merge d0", 32'h500, 32'h5555_5555, BE_WORD);
        drain_one("merge d1", 32'h504, 32'h6666_6666, BE_WORD);
`ifdef STORE_MERGE_EN
        drain_one("merge d2", 32'h400, 32'h00BB_00AA, 4'b0101);
`else
        drain_one("merge d2", 32'h400, 32'h0000_00AA, 4'b0001);
        drain_one("merge d3", 32'h400, 32'h00BB_0000, 4'b0100);
`endif
        expect_idle("merge end");

        // Youngest entry is the head under request: the push must allocate.
        do_reset();
        push(32'h600, 32'h0000_0001, 4'b0001);
        tick();
        push(32'h600, 32'h0000_0200, 4'b0010);
        load_check("nomerge fwd", 32'h600, 4'b0011, 32'h0000_0201, 1'b1, 1'b0);
        drain_one("nomerge d0", 32'h600, 32'h0000_0001, 4'b0001);
        drain_one("nomerge d1", 32'h600, 32'h0000_0200, 4'b0010);
        expect_idle("nomerge end");

        // Reset mid-drain drops mem_req at once; afterwards the buffer is empty.
        push(32'h700, 32'h7777_7777, BE_WORD);
        tick();
        check("rstmid req", mem_req, 1'b1);
        reset_n = 1'b0;
        #1;
        check("rstmid req dropped", mem_req, 1'b0);
        check("rstmid addr", mem_addr, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        check("rstmid ready", st_ready, 1'b1);
        expect_idle("rstmid after");

        // Zero byte-enable store is accepted but creates nothing.
        st_valid = 1'b1; st_addr = 32'h800; st_wdata = 32'hFFFF_FFFF; st_be = BE_NONE;
        #1;
        check("be0 ready", st_ready, 1'b1);
        tick();
        st_valid = 1'b0;
        expect_idle("be0");
        load_check("be0 fwd", 32'h800, BE_WORD, 32'h0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
